// File: rtl/gate_vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gate_vector_sequencer
// Brief    : Drives exhaustive input vectors into a small XNOR-style gate,
//            holds each vector for a settle time, samples the gate output,
//            and compares it against the expected even-parity result.
//            Counts mismatches, captures the first failing vector, and
//            reports done/pass.
// Revision : 1.0 - initial release
// ============================================================================
module gate_vector_sequencer #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec
);

    // Settle counter only has to reach SETTLE_CYCLES-1.
    localparam int                c_CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]   c_VEC_LAST    = '1;
    localparam logic [N_IN:0]     c_ERR_MAX     = '1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [N_IN:0]      err_q, err_d;
    logic               fev_q, fev_d;
    logic [N_IN-1:0]    fvec_q, fvec_d;

    logic               w_expected;
    logic               w_mismatch;
    logic [N_IN:0]      w_err_next;

    // Expected gate response is even parity; an unknown gate output is
    // treated as a mismatch by using the case-equality compare.
    assign w_expected = ~^vec_q;
    assign w_mismatch = !(dut_y === w_expected);
    assign w_err_next = (w_mismatch && (err_q != c_ERR_MAX)) ? (err_q + (N_IN+1)'(1)) : err_q;

    // Next-state logic for the sequencing FSM and its result registers.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fvec_d  = fvec_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    state_d = c_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fvec_d  = '0;
                end
            end
            c_SETTLE: begin
                if (cnt_q == c_SETTLE_LAST) begin
                    state_d = c_SAMPLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_SAMPLE: begin
                err_d = w_err_next;
                if (w_mismatch && !fev_q) begin
                    fev_d  = 1'b1;
                    fvec_d = vec_q;
                end
                if (vec_q != c_VEC_LAST) begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = c_SETTLE;
                end else begin
                    state_d = c_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (w_err_next == '0);
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gate_vector_sequencer
// Brief    : Self-checking bench for gate_vector_sequencer. Three instances:
//            defaults (2,2), N_IN=3, and SETTLE_CYCLES=1, driven by a shared
//            start/reset and fed by a selectable behavioural gate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_vector_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;

    logic [1:0] vec0;  logic [2:0] vec1;  logic [1:0] vec2;
    logic       y0, y1, y2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [2:0] err0;  logic [3:0] err1;  logic [2:0] err2;
    logic       fev0, fev1, fev2;
    logic [1:0] fvec0; logic [2:0] fvec1; logic [1:0] fvec2;

    typedef struct {
        int   err;
        int   first;
        logic fv;
        logic pass;
    } res_t;

    res_t rq[$];
    int   vq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Behavioural gate: 0 = XNOR, 1 = stuck-at-0, 2 = XOR, 3 = XNOR wrong at vector 2
    function automatic logic gate(int m, logic [7:0] v, int n);
        logic p;
        p = 1'b1;
        for (int i = 0; i < n; i++) p = p ^ v[i];
        case (m)
            0:       return p;
            1:       return 1'b0;
            2:       return ~p;
            default: return (v == 8'd2) ? ~p : p;
        endcase
    endfunction

    always_comb y0 = gate(mode, {6'b0, vec0}, 2);
    always_comb y1 = gate(mode, {5'b0, vec1}, 3);
    always_comb y2 = gate(mode, {6'b0, vec2}, 2);

    gate_vector_sequencer #(.N_IN(2), .SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_vec(fvec0)
    );
    gate_vector_sequencer #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fev1), .first_err_vec(fvec1)
    );
    gate_vector_sequencer #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_valid(fev2), .first_err_vec(fvec2)
    );

    // One full run: scoreboard per-cycle vec_out for the default instance,
    // then check done timing and final results on all three instances.
    task automatic run_check(string name, int m, int e0, int f0, int e1, int f1, int glitch);
        res_t r;
        int   d0, d1, d2, ev;
        d0 = -1; d1 = -1; d2 = -1;
        mode = m;
        vq.delete();
        r.err = e0; r.first = f0; r.fv = (e0 != 0); r.pass = (e0 == 0);
        rq.push_back(r);
        for (int k = 0; k < 12; k++) vq.push_back(k / 3);
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            if (glitch > 0 && k == glitch) start = 1'b1;
            else if (glitch > 0 && k == glitch + 1) start = 1'b0;
            if (vq.size() > 0) begin
                ev = vq.pop_front();
                total++;
                if (vec0 !== 2'(ev) || busy0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_cyc%0d: vec=%0d busy=%b done=%b pass=%b, want vec=%0d busy=1 done=0 pass=0",
                             name, k, vec0, busy0, done0, pass0, ev);
                end
            end
            if (done0 && d0 < 0) d0 = k;
            if (done1 && d1 < 0) d1 = k;
            if (done2 && d2 < 0) d2 = k;
            if (d0 >= 0 && d1 >= 0 && d2 >= 0) break;
        end
        total++;
        if (d0 != 12) begin bad++; $display("FAIL %s_done_edge0: got %0d want 12", name, d0); end
        total++;
        if (d1 != 24) begin bad++; $display("FAIL %s_done_edge1: got %0d want 24", name, d1); end
        total++;
        if (d2 != 8) begin bad++; $display("FAIL %s_done_edge2: got %0d want 8", name, d2); end
        r = rq.pop_front();
        total++;
        if (err0 !== 3'(r.err) || fvec0 !== 2'(r.first) || fev0 !== r.fv || pass0 !== r.pass ||
            busy0 !== 1'b0 || vec0 !== 2'd3) begin
            bad++;
            $display("FAIL %s_res0: err=%0d fvec=%0d fev=%b pass=%b busy=%b vec=%0d, want err=%0d fvec=%0d fev=%b pass=%b busy=0 vec=3",
                     name, err0, fvec0, fev0, pass0, busy0, vec0, r.err, r.first, r.fv, r.pass);
        end
        total++;
        if (err1 !== 4'(e1) || fvec1 !== 3'(f1) || fev1 !== (e1 != 0) || pass1 !== (e1 == 0)) begin
            bad++;
            $display("FAIL %s_res1: err=%0d fvec=%0d fev=%b pass=%b, want err=%0d fvec=%0d",
                     name, err1, fvec1, fev1, pass1, e1, f1);
        end
        total++;
        if (err2 !== 3'(e0) || fvec2 !== 2'(f0) || fev2 !== (e0 != 0) || pass2 !== (e0 == 0)) begin
            bad++;
            $display("FAIL %s_res2: err=%0d fvec=%0d fev=%b pass=%b, want err=%0d fvec=%0d",
                     name, err2, fvec2, fev2, pass2, e0, f0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({vec0, busy0, done0, pass0, err0, fev0, fvec0} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state0: vec=%0d busy=%b done=%b pass=%b err=%0d fev=%b fvec=%0d, want all 0",
                     vec0, busy0, done0, pass0, err0, fev0, fvec0);
        end
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 4'd0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state12: busy1=%b done1=%b err1=%0d busy2=%b done2=%b, want 0",
                     busy1, done1, err1, busy2, done2);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy0 !== 1'b0 || vec0 !== 2'd0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b vec=%0d done=%b, want 0 0 0", busy0, vec0, done0);
        end
    endtask

    task automatic test_correct();    run_check("xnor",   0, 0, 0, 0, 0, 0); endtask
    task automatic test_stuck0();     run_check("stuck0", 1, 2, 0, 4, 0, 0); endtask
    task automatic test_xor();        run_check("xor",    2, 4, 0, 8, 0, 0); endtask
    task automatic test_wrong_10();   run_check("bad10",  3, 1, 2, 1, 2, 0); endtask

    task automatic test_reset_midrun();
        mode = 0;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        total++;
        if (vec0 !== 2'd1 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pre: vec=%0d busy=%b, want 1 1", vec0, busy0);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({vec0, busy0, done0, pass0, err0, fev0, fvec0} !== 11'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL midrun_rst: vec=%0d busy=%b done=%b err=%0d busy1=%b busy2=%b, want 0",
                     vec0, busy0, done0, err0, busy1, busy2);
        end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (busy0 !== 1'b0 || vec0 !== 2'd0) begin
            bad++;
            $display("FAIL midrun_idle: busy=%b vec=%0d, want 0 0", busy0, vec0);
        end
        run_check("after_rst", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_start_busy();  run_check("busy_start", 0, 0, 0, 0, 0, 4); endtask
    task automatic test_back_to_back(); run_check("restart",   2, 4, 0, 8, 0, 0); endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck0();
        test_xor();
        test_wrong_10();
        test_reset_midrun();
        test_start_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Self-checking stimulus and response stage for small combinational gates. It drives exhaustive input vectors into an XNOR-style gate under test, waits a settle time for each vector, samples the gate output and compares it against the expected even-parity (XNOR) result. It counts mismatches, captures the first failing vector, and reports done and pass. It sits directly upstream of the gate, driving its inputs, and directly downstream of it, consuming its output. It replaces hand-written timed stimulus with a clocked, synthesizable checker.

Parameters:
N_IN, 2, number of gate inputs; vectors run 0 to 2^N_IN-1; legal range 1..8.
SETTLE_CYCLES, 2, cycles each vector is held before it is sampled; legal range >= 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle or level request to begin a run; honoured only in IDLE or DONE.
vec_out  output  N_IN  vector driven to the gate; MSB = A, LSB = B when N_IN = 2.
dut_y  input  1  gate output, sampled in the SAMPLE state.
busy  output  1  high while a run is in progress (SETTLE or SAMPLE).
done  output  1  high in DONE until the next start or reset.
pass  output  1  valid when done = 1; 1 when err_count = 0.
err_count  output  N_IN+1  mismatch count; saturates at all-ones.
first_err_valid  output  1  a mismatch has been captured in this run.
first_err_vec  output  N_IN  vector of the first mismatch; 0 when none.

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst = 1 at an edge): state goes to IDLE, and vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec all go to 0. Reset overrides start. Reset mid-run aborts the run with no partial result retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: vec_out = 0, busy = 0.
  - start = 1 → SETTLE.
  - On that edge: vec_out <= 0, settle_cnt <= 0, busy <= 1, done <= 0, pass <= 0, err_count <= 0, first_err_valid <= 0, first_err_vec <= 0.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1 → SAMPLE.
  - vec_out is stable throughout.
- SAMPLE (one cycle): expected = ~^vec_out.
  - Mismatch (dut_y != expected; X or Z counts as mismatch in simulation): err_count increments, saturating.
  - On a mismatch with first_err_valid = 0: first_err_vec <= vec_out, first_err_valid <= 1.
  - vec_out != all-ones: vec_out <= vec_out+1, settle_cnt <= 0 → SETTLE.
  - vec_out == all-ones: → DONE. On the same edge: busy <= 0, done <= 1, pass <= (final err_count including this sample == 0). vec_out holds its last value.
- DONE: outputs hold. start = 1 restarts exactly as from IDLE; done clears on that edge.
- start while busy = 1 is ignored. A level-held start re-triggers a run each time DONE is reached.
- Each vector occupies SETTLE_CYCLES+1 cycles. done rises 2^N_IN × (SETTLE_CYCLES+1) edges after the edge that accepted start. With the defaults this is 12 edges.
- Sampling uses the dut_y value present at the SAMPLE-state edge. The gate path must settle within SETTLE_CYCLES cycles.

Test Plan:
1. Correct XNOR gate, defaults, 1-cycle start pulse → vec_out steps 00, 01, 10, 11, each held 3 cycles. busy is high for 12 cycles. done = 1 at edge 12, pass = 1, err_count = 0, first_err_valid = 0.
2. dut_y stuck at 0 → mismatches at vectors 00 and 11. err_count = 2, first_err_vec = 00, first_err_valid = 1, pass = 0.
3. XOR gate substituted → all 4 vectors fail. err_count = 4, first_err_vec = 00, pass = 0. Repeat with N_IN = 3: err_count = 8, and no saturation (width 4).
4. Gate wrong only at A = 1, B = 0 → err_count = 1, first_err_vec = 10. pass = 0 only after done.
5. rst asserted at cycle 5 of a run (vec_out = 01) → next edge: all outputs 0, state IDLE. A new start gives a clean full run with results identical to scenario 1.
6. start pulsed during busy → ignored, timing unchanged. start pulsed in DONE → done = 0 next edge, vec_out = 00, new run completes. SETTLE_CYCLES = 1 → done at edge 8.
